// File: rtl/ras_ctrl.sv
// ras_ctrl: sequencer between the control unit and the 8-entry return-address
// stack. Turns accepted CALL/RET requests into single-cycle push/pop strobes,
// tracks how many entries are live, raises sticky overflow/underflow flags and
// returns the popped address to the PC-select logic.
module ras_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              call_req,
    input  logic              ret_req,
    input  logic [ADDR_W-1:0] call_addr,
    output logic              req_ready,
    output logic              stk_push,
    output logic              stk_pop,
    output logic [ADDR_W-1:0] stk_addr,
    input  logic [ADDR_W-1:0] stk_top,
    output logic              ret_valid,
    output logic [ADDR_W-1:0] ret_target,
    output logic [CNT_W-1:0]  depth,
    output logic              full,
    output logic              empty,
    output logic              ovf_err,
    output logic              unf_err,
    input  logic              err_clr
);

    localparam logic [CNT_W-1:0] DEPTH_MAX = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        READ = 2'd2,
        POP  = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_ready;
    logic              r_push;
    logic              r_pop;
    logic [ADDR_W-1:0] r_addr;
    logic              r_ret_valid;
    logic [ADDR_W-1:0] r_ret_target;
    logic [CNT_W-1:0]  r_depth;
    logic              r_ovf;
    logic              r_unf;

    logic              w_full;
    logic              w_empty;

    // Full/empty come straight from the registered depth so they never lag it.
    assign w_full  = (r_depth == DEPTH_MAX);
    assign w_empty = (r_depth == '0);

    // Request sequencer: strobes, depth, return target and sticky errors all
    // change on the same edge; RET wins over CALL when both are presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_ready      <= 1'b1;
            r_push       <= 1'b0;
            r_pop        <= 1'b0;
            r_addr       <= '0;
            r_ret_valid  <= 1'b0;
            r_ret_target <= '0;
            r_depth      <= '0;
            r_ovf        <= 1'b0;
            r_unf        <= 1'b0;
        end else begin
            r_push      <= 1'b0;
            r_pop       <= 1'b0;
            r_ret_valid <= 1'b0;

            if (err_clr) begin
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (ret_req) begin
                        if (w_empty) begin
                            r_unf <= 1'b1;
                        end else begin
                            r_state <= READ;
                            r_ready <= 1'b0;
                        end
                    end else if (call_req) begin
                        if (w_full) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_state <= PUSH;
                            r_ready <= 1'b0;
                            r_push  <= 1'b1;
                            r_addr  <= call_addr;
                            r_depth <= r_depth + CNT_ONE;
                        end
                    end
                end
                PUSH: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
                READ: begin
                    r_state      <= POP;
                    r_ret_target <= stk_top;
                    r_pop        <= 1'b1;
                    r_ret_valid  <= 1'b1;
                    r_depth      <= r_depth - CNT_ONE;
                end
                POP: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_ready;
    assign stk_push   = r_push;
    assign stk_pop    = r_pop;
    assign stk_addr   = r_addr;
    assign ret_valid  = r_ret_valid;
    assign ret_target = r_ret_target;
    assign depth      = r_depth;
    assign full       = w_full;
    assign empty      = w_empty;
    assign ovf_err    = r_ovf;
    assign unf_err    = r_unf;

endmodule

// File: tb/tb_ras_ctrl.sv
// tb_ras_ctrl: directed vector bench for ras_ctrl with a small behavioural
// return-address stack attached to the push/pop strobes.
module tb_ras_ctrl;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;
    localparam int NVEC   = 23;

    logic              clk;
    logic              rst;
    logic              call_req;
    logic              ret_req;
    logic [ADDR_W-1:0] call_addr;
    logic              req_ready;
    logic              stk_push;
    logic              stk_pop;
    logic [ADDR_W-1:0] stk_addr;
    logic [ADDR_W-1:0] stk_top;
    logic              ret_valid;
    logic [ADDR_W-1:0] ret_target;
    logic [CNT_W-1:0]  depth;
    logic              full;
    logic              empty;
    logic              ovf_err;
    logic              unf_err;
    logic              err_clr;

    int errors = 0;
    int checks = 0;

    ras_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .call_req   (call_req),
        .ret_req    (ret_req),
        .call_addr  (call_addr),
        .req_ready  (req_ready),
        .stk_push   (stk_push),
        .stk_pop    (stk_pop),
        .stk_addr   (stk_addr),
        .stk_top    (stk_top),
        .ret_valid  (ret_valid),
        .ret_target (ret_target),
        .depth      (depth),
        .full       (full),
        .empty      (empty),
        .ovf_err    (ovf_err),
        .unf_err    (unf_err),
        .err_clr    (err_clr)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stack: commits pushes/pops on the edge that ends the strobe.
    logic [ADDR_W-1:0] stackMem [0:15];
    int                stackCnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            stackCnt <= 0;
        end else if (stk_push) begin
            stackMem[stackCnt] <= stk_addr;
            stackCnt           <= stackCnt + 1;
        end else if (stk_pop && stackCnt > 0) begin
            stackCnt <= stackCnt - 1;
        end
    end

    assign stk_top = (stackCnt == 0) ? '0 : stackMem[stackCnt-1];

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        logic              rst;
        logic              call;
        logic              ret;
        logic              clr;
        logic [ADDR_W-1:0] addr;
        logic              eReady;
        logic              ePush;
        logic              ePop;
        logic [ADDR_W-1:0] eAddr;
        logic              eRv;
        logic [ADDR_W-1:0] eTgt;
        logic [CNT_W-1:0]  eDepth;
        logic              eOvf;
        logic              eUnf;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic r, input logic c, input logic rt,
                                input logic cl, input logic [ADDR_W-1:0] a,
                                input logic ery, input logic eps, input logic epp,
                                input logic [ADDR_W-1:0] ea, input logic erv,
                                input logic [ADDR_W-1:0] et, input logic [CNT_W-1:0] ed,
                                input logic eo, input logic eu);
        vec_t v;
        v.rst = r;  v.call = c;  v.ret = rt;  v.clr = cl;  v.addr = a;
        v.eReady = ery;  v.ePush = eps;  v.ePop = epp;  v.eAddr = ea;
        v.eRv = erv;  v.eTgt = et;  v.eDepth = ed;  v.eOvf = eo;  v.eUnf = eu;
        return v;
    endfunction

    // Drive one cycle of inputs at the falling edge, then settle past the rising edge.
    task automatic applyStimulus(input logic r, input logic c, input logic rt,
                                 input logic cl, input logic [ADDR_W-1:0] a);
        @(negedge clk);
        rst       = r;
        call_req  = c;
        ret_req   = rt;
        err_clr   = cl;
        call_addr = a;
        @(posedge clk);
        #1;
    endtask

    task automatic checkField(input string name, input string field,
                              input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s got=0x%0h expected=0x%0h", name, field, got, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic eReady, input logic ePush,
                               input logic ePop, input logic [ADDR_W-1:0] eAddr,
                               input logic eRv, input logic [ADDR_W-1:0] eTgt,
                               input logic [CNT_W-1:0] eDepth, input logic eOvf,
                               input logic eUnf);
        checkField(name, "req_ready",  32'(req_ready),  32'(eReady));
        checkField(name, "stk_push",   32'(stk_push),   32'(ePush));
        checkField(name, "stk_pop",    32'(stk_pop),    32'(ePop));
        if (ePush)
            checkField(name, "stk_addr", 32'(stk_addr), 32'(eAddr));
        checkField(name, "ret_valid",  32'(ret_valid),  32'(eRv));
        checkField(name, "ret_target", 32'(ret_target), 32'(eTgt));
        checkField(name, "depth",      32'(depth),      32'(eDepth));
        checkField(name, "full",       32'(full),       32'(eDepth == CNT_W'(DEPTH)));
        checkField(name, "empty",      32'(empty),      32'(eDepth == '0));
        checkField(name, "ovf_err",    32'(ovf_err),    32'(eOvf));
        checkField(name, "unf_err",    32'(unf_err),    32'(eUnf));
    endtask

    initial begin
        logic [ADDR_W-1:0] lastTgt;
        rst = 1'b1;  call_req = 1'b0;  ret_req = 1'b0;  err_clr = 1'b0;  call_addr = '0;

        //            rst call ret clr addr     rdy psh pop saddr    rv tgt      dep ovf unf
        vecs[0]  = mk(1, 0, 0, 0, 12'h000,  1, 0, 0, 12'h000, 0, 12'h000, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 12'h000,  1, 0, 0, 12'h000, 0, 12'h000, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 12'h000,  1, 0, 0, 12'h000, 0, 12'h000, 0, 0, 0);
        vecs[3]  = mk(0, 1, 0, 0, 12'h123,  0, 1, 0, 12'h123, 0, 12'h000, 1, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0, 12'h000,  1, 0, 0, 12'h000, 0, 12'h000, 1, 0, 0);
        vecs[5]  = mk(0, 1, 0, 0, 12'h0A0,  0, 1, 0, 12'h0A0, 0, 12'h000, 2, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 12'h000,  1, 0, 0, 12'h000, 0, 12'h000, 2, 0, 0);
        vecs[7]  = mk(0, 1, 0, 0, 12'h0B0,  0, 1, 0, 12'h0B0, 0, 12'h000, 3, 0, 0);
        vecs[8]  = mk(0, 0, 0, 0, 12'h000,  1, 0, 0, 12'h000, 0, 12'h000, 3, 0, 0);
        vecs[9]  = mk(0, 0, 1, 0, 12'h000,  0, 0, 0, 12'h000, 0, 12'h000, 3, 0, 0);
        vecs[10] = mk(0, 0, 0, 0, 12'h000,  0, 0, 1, 12'h000, 1, 12'h0B0, 2, 0, 0);
        vecs[11] = mk(0, 0, 0, 0, 12'h000,  1, 0, 0, 12'h000, 0, 12'h0B0, 2, 0, 0);
        vecs[12] = mk(0, 0, 1, 0, 12'h000,  0, 0, 0, 12'h000, 0, 12'h0B0, 2, 0, 0);
        vecs[13] = mk(0, 0, 0, 0, 12'h000,  0, 0, 1, 12'h000, 1, 12'h0A0, 1, 0, 0);
        vecs[14] = mk(0, 0, 0, 0, 12'h000,  1, 0, 0, 12'h000, 0, 12'h0A0, 1, 0, 0);
        vecs[15] = mk(0, 0, 1, 0, 12'h000,  0, 0, 0, 12'h000, 0, 12'h0A0, 1, 0, 0);
        vecs[16] = mk(0, 0, 0, 0, 12'h000,  0, 0, 1, 12'h000, 1, 12'h123, 0, 0, 0);
        vecs[17] = mk(0, 0, 0, 0, 12'h000,  1, 0, 0, 12'h000, 0, 12'h123, 0, 0, 0);
        vecs[18] = mk(0, 0, 1, 0, 12'h000,  1, 0, 0, 12'h000, 0, 12'h123, 0, 0, 1);
        vecs[19] = mk(0, 0, 0, 0, 12'h000,  1, 0, 0, 12'h000, 0, 12'h123, 0, 0, 1);
        vecs[20] = mk(0, 0, 0, 1, 12'h000,  1, 0, 0, 12'h000, 0, 12'h123, 0, 0, 0);
        vecs[21] = mk(0, 0, 1, 1, 12'h000,  1, 0, 0, 12'h000, 0, 12'h123, 0, 0, 1);
        vecs[22] = mk(0, 0, 0, 1, 12'h000,  1, 0, 0, 12'h000, 0, 12'h123, 0, 0, 0);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].call, vecs[i].ret, vecs[i].clr, vecs[i].addr);
            checkOutput($sformatf("vec%0d", i), vecs[i].eReady, vecs[i].ePush, vecs[i].ePop,
                        vecs[i].eAddr, vecs[i].eRv, vecs[i].eTgt, vecs[i].eDepth,
                        vecs[i].eOvf, vecs[i].eUnf);
        end
        lastTgt = 12'h123;

        // Fill the stack with eight CALLs.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, ADDR_W'(12'h200 + i));
            checkOutput($sformatf("fill%0d_push", i), 1'b0, 1'b1, 1'b0, ADDR_W'(12'h200 + i),
                        1'b0, lastTgt, CNT_W'(i + 1), 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
            checkOutput($sformatf("fill%0d_idle", i), 1'b1, 1'b0, 1'b0, '0,
                        1'b0, lastTgt, CNT_W'(i + 1), 1'b0, 1'b0);
        end

        // Ninth CALL while full is rejected and sets the sticky overflow flag.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'h2FF);
        checkOutput("ovf_call", 1'b1, 1'b0, 1'b0, '0, 1'b0, lastTgt, 4'd8, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("ovf_sticky", 1'b1, 1'b0, 1'b0, '0, 1'b0, lastTgt, 4'd8, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
        checkOutput("ovf_clr", 1'b1, 1'b0, 1'b0, '0, 1'b0, lastTgt, 4'd8, 1'b0, 1'b0);

        // Drain in LIFO order.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0);
            checkOutput($sformatf("drain%0d_read", i), 1'b0, 1'b0, 1'b0, '0,
                        1'b0, lastTgt, CNT_W'(i + 1), 1'b0, 1'b0);
            lastTgt = ADDR_W'(12'h200 + i);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
            checkOutput($sformatf("drain%0d_pop", i), 1'b0, 1'b0, 1'b1, '0,
                        1'b1, lastTgt, CNT_W'(i), 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
            checkOutput($sformatf("drain%0d_idle", i), 1'b1, 1'b0, 1'b0, '0,
                        1'b0, lastTgt, CNT_W'(i), 1'b0, 1'b0);
        end

        // Depth 1, then CALL and RET together: RET is served, CALL waits.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'h055);
        checkOutput("both_pre_push", 1'b0, 1'b1, 1'b0, 12'h055, 1'b0, lastTgt, 4'd1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("both_pre_idle", 1'b1, 1'b0, 1'b0, '0, 1'b0, lastTgt, 4'd1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'h066);
        checkOutput("both_read", 1'b0, 1'b0, 1'b0, '0, 1'b0, lastTgt, 4'd1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'h066);
        checkOutput("both_pop", 1'b0, 1'b0, 1'b1, '0, 1'b1, 12'h055, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'h066);
        checkOutput("both_idle", 1'b1, 1'b0, 1'b0, '0, 1'b0, 12'h055, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'h066);
        checkOutput("both_call", 1'b0, 1'b1, 1'b0, 12'h066, 1'b0, 12'h055, 4'd1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("both_call_idle", 1'b1, 1'b0, 1'b0, '0, 1'b0, 12'h055, 4'd1, 1'b0, 1'b0);

        // Reset during READ suppresses the pop and clears depth.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0);
        checkOutput("rst_read", 1'b0, 1'b0, 1'b0, '0, 1'b0, 12'h055, 4'd1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("rst_in_read", 1'b1, 1'b0, 1'b0, '0, 1'b0, 12'h000, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("rst_after", 1'b1, 1'b0, 1'b0, '0, 1'b0, 12'h000, 4'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
